pipelined_barrel_shifter: RTL and testbench

//  Parametrised, pipelined barrel shifter for the processor execute stage; successor to the 32-bit combinational left shifter.

---
 rtl/shifter_pkg.sv | 12 +
 rtl/shift_level.sv | 30 +++
 rtl/pipelined_barrel_shifter.sv | 124 ++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: shift operation
// encodings and the operation type carried down the pipeline.
package shifter_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } shift_op_t;

endpackage

// File: rtl/shift_level.sv
// One combinational mux level of the barrel shifter: shifts by SHIFT when en is set.
// Rotate muxing is only built when SHIFTER_ROTATE_EN is defined; otherwise op 11 acts as SLL.
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] din,
    input  shift_op_t        op,
    input  logic             en,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        // NOTE: dout gets a default before the case so no path through this block can infer a latch.
        dout = din;
        if (en) begin
            case (op)
                OP_SRL:  dout = din >> SHIFT;
                OP_SRA:  dout = $signed(din) >>> SHIFT;
`ifdef SHIFTER_ROTATE_EN
                OP_ROL:  dout = {din[WIDTH-SHIFT-1:0], din[WIDTH-1:WIDTH-SHIFT]};
`endif
                default: dout = din << SHIFT;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA(/ROL) barrel shifter with valid/ready on both sides and a passthrough tag.
// Define SHIFTER_ROTATE_EN to turn op 11 into rotate-left; otherwise it behaves as SLL.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int AMT_W     = $clog2(WIDTH),
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LAT = (AMT_W + REG_EVERY - 1) / REG_EVERY;
    localparam int QN  = (LAT > 1) ? LAT - 1 : 1;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [AMT_W-1:0] amt;
        shift_op_t        op;
        logic [TAG_W-1:0] tag;
    } payload_t;

    payload_t         src [LAT];   // payload entering each stage's mux levels
    payload_t         nxt [LAT];   // payload leaving each stage's mux levels
    payload_t         q   [QN];    // intermediate stage registers
    logic [WIDTH-1:0] lvl_in  [AMT_W];
    logic [WIDTH-1:0] lvl_out [AMT_W];

    logic [LAT-1:0] v, v_next, free, ld;

    assign src[0] = '{data: in_data, amt: in_amt, op: shift_op_t'(in_op), tag: in_tag};

    genvar gi;
    generate
        for (gi = 1; gi < LAT; gi++) begin : g_src
            assign src[gi] = q[gi-1];
        end

        for (gi = 0; gi < AMT_W; gi++) begin : g_lvl
            localparam int S = gi / REG_EVERY;
            if (gi % REG_EVERY == 0) begin : g_head
                assign lvl_in[gi] = src[S].data;
            end else begin : g_chain
                assign lvl_in[gi] = lvl_out[gi-1];
            end
            shift_level #(.WIDTH(WIDTH), .SHIFT(1 << gi)) u_level (
                .din  (lvl_in[gi]),
                .op   (src[S].op),
                .en   (src[S].amt[gi]),
                .dout (lvl_out[gi])
            );
        end

        for (gi = 0; gi < LAT; gi++) begin : g_stage
            localparam int END  = ((gi + 1) * REG_EVERY < AMT_W) ? (gi + 1) * REG_EVERY : AMT_W;
            assign nxt[gi] = '{data: lvl_out[END-1], amt: src[gi].amt, op: src[gi].op, tag: src[gi].tag};

            if (gi < LAT - 1) begin : g_mid
                // NOTE: intermediate data registers carry no reset; their valid bit alone qualifies them.
                always_ff @(posedge clock) begin
                    if (ld[gi]) q[gi] <= nxt[gi];
                end
            end else begin : g_out
                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n) begin
                        out_data <= '0;
                        out_tag  <= '0;
                    end else if (ld[gi]) begin
                        out_data <= nxt[gi].data;
                        out_tag  <= nxt[gi].tag;
                    end
                end
            end
        end
    endgenerate

    // A stage may load when it, or any stage after it, has a hole, or the output drains.
    always_comb begin
        free = '0;
        for (int s = 0; s < LAT; s++) begin
            free[s] = out_ready;
            for (int k = s; k < LAT; k++) begin
                if (!v[k]) free[s] = 1'b1;
            end
        end
    end

    assign in_ready = reset_n & ~flush & free[0];

    always_comb begin
        ld     = '0;
        v_next = v;
        ld[0]  = in_valid & in_ready;
        for (int s = 1; s < LAT; s++) begin
            ld[s] = v[s-1] & free[s];
        end
        for (int s = 0; s < LAT; s++) begin
            if (free[s]) v_next[s] = (s == 0) ? ld[0] : v[s-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state updates use non-blocking assignments only.
        if (!reset_n)   v <= '0;
        else if (flush) v <= '0;
        else            v <= v_next;
    end

    assign out_valid = v[LAT-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter: directed latency, backpressure,
// flush and reset cases plus randomized traffic checked against a scoreboard model.
module tb_pipelined_barrel_shifter;
    import shifter_pkg::*;

    localparam int WIDTH = 32;
    localparam int AMT_W = 5;
    localparam int TAG_W = 5;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [AMT_W-1:0] in_amt = '0;
    logic [1:0]       in_op = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    pipelined_barrel_shifter #(.WIDTH(WIDTH), .REG_EVERY(2), .TAG_W(TAG_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             sb[$];
    int               errors = 0;
    int               checks = 0;
    logic             in_fire, out_fire;
    logic [WIDTH-1:0] last_out_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference shifter: whole-word arithmetic on a double-width value.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d, input int a,
                                                   input logic [1:0] op);
        logic [2*WIDTH-1:0] wide;
        case (op)
            2'b01: return d >> a;
            2'b10: begin
                wide = {{WIDTH{d[WIDTH-1]}}, d} >> a;
                return wide[WIDTH-1:0];
            end
            2'b11: begin
`ifdef SHIFTER_ROTATE_EN
                wide = {d, d} << a;
                return wide[2*WIDTH-1:WIDTH];
`else
                return d << a;
`endif
            end
            default: return d << a;
        endcase
    endfunction

    // One cycle: inputs are already applied; evaluate handshakes mid-low-phase, then advance.
    task automatic tick();
        exp_t e;
        #1;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready && !flush;
        if (in_fire) sb.push_back('{ref_shift(in_data, int'(in_amt), in_op), in_tag});
        if (out_fire) begin
            last_out_data = out_data;
            if (sb.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("out_data", out_data, e.data);
                check("out_tag", 32'(out_tag), 32'(e.tag));
            end
        end
        if (flush) sb.delete();
        @(negedge clock);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] a,
                         input logic [1:0] op, input logic [4:0] t);
        in_valid = v;
        in_data  = d;
        in_amt   = a;
        in_op    = op;
        in_tag   = t;
    endtask

    // Issue one op into an idle pipe and check arrival after exactly three cycles.
    task automatic latency_test(input string name, input logic [31:0] d, input logic [4:0] a,
                                input logic [1:0] op, input logic [4:0] t, input logic [31:0] exp);
        int first;
        first = 0;
        out_ready = 1'b1;
        drive(1'b1, d, a, op, t);
        tick();
        check({name, "_accept"}, 32'(in_fire), 32'd1);
        in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (out_fire && first == 0) first = i;
        end
        check({name, "_latency"}, first, 3);
        check({name, "_value"}, last_out_data, exp);
    endtask

    initial begin
        logic [31:0] items [5];
        logic [31:0] hold;
        int          idx;
        int          seen;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed single-op cases
        latency_test("sll31", 32'h0000_0001, 5'd31, 2'b00, 5'd1, 32'h8000_0000);
        latency_test("srl4", 32'h8000_0000, 5'd4, 2'b01, 5'd2, 32'h0800_0000);
        latency_test("sra4", 32'h8000_0000, 5'd4, 2'b10, 5'd3, 32'hF800_0000);
        for (int op = 0; op < 4; op++) begin
            latency_test("amt0", 32'hA5C3_1234, 5'd0, 2'(op), 5'(op + 4), 32'hA5C3_1234);
        end
`ifdef SHIFTER_ROTATE_EN
        latency_test("op11", 32'h8000_0001, 5'd1, 2'b11, 5'd9, 32'h0000_0003);
`else
        latency_test("op11", 32'h8000_0001, 5'd1, 2'b11, 5'd9, 32'h0000_0002);
`endif

        // Backpressure: five back-to-back with out_ready low
        for (int i = 0; i < 5; i++) items[i] = $urandom;
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(idx < 5, items[idx < 5 ? idx : 4], 5'(idx * 3 + 1), 2'(idx), 5'(10 + idx));
            tick();
            if (in_fire) idx++;
        end
        check("bp_accepted", idx, 3);
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        hold = out_data;
        tick();
        tick();
        #1;
        check("bp_hold", out_data, hold);
        out_ready = 1'b1;
        for (int c = 0; c < 40 && (idx < 5 || sb.size() != 0); c++) begin
            drive(idx < 5, items[idx < 5 ? idx : 4], 5'(idx * 3 + 1), 2'(idx), 5'(10 + idx));
            tick();
            if (in_fire) idx++;
        end
        in_valid = 1'b0;
        check("bp_all_in", idx, 5);
        check("bp_drained", sb.size(), 0);

        // Flush with two in flight and in_valid high
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, $urandom, 5'd7, 2'b01, 5'(20 + i));
            tick();
        end
        drive(1'b1, 32'hDEAD_BEEF, 5'd3, 2'b00, 5'd22);
        flush = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_fire) seen++;
        end
        check("flush_no_out", seen, 0);
        latency_test("post_flush", 32'h0000_00F0, 5'd4, 2'b00, 5'd23, 32'h0000_0F00);

        // Asynchronous reset with three in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 5'(i), 2'b00, 5'(24 + i));
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        sb.delete();
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_fire) seen++;
        end
        check("rst_no_stale", seen, 0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            drive(($urandom % 4) != 0, $urandom, 5'($urandom), 2'($urandom), 5'($urandom));
            out_ready = ($urandom % 4) != 0;
            flush = ($urandom % 40) == 0;
            tick();
        end
        drive(1'b0, '0, '0, '0, '0);
        flush = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
        check("rand_drained", sb.size(), 0);
        #1;
        check("rand_idle", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
